// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM
// state encoding, datapath select encodings and the control vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  // Full set of datapath controls produced by the output decoder.
  typedef struct packed {
    logic   pc_write;
    logic   branch;
    logic   iord;
    logic   mem_write;
    logic   ir_write;
    logic   reg_dst;
    logic   memto_reg;
    logic   reg_write;
    logic   alu_src_a;
    srcb_t  alu_src_b;
    pcsrc_t pc_src;
    aluop_t alu_op;
    logic   instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the current state (plus the effective memory
// ready, which only gates FETCH writes and the SW completion) to controls.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control vector; anything not named for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memto_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Memory handshake: mem_ready high in a memory state (FETCH, MEMRD, MEMWR)
// means the access completes this cycle and the FSM advances on the next
// rising edge; while it is low the FSM holds with its controls unchanged.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t           state_q, state_d;
  ctrl_t            ctrl;
  logic             mem_rdy;
  logic             illegal;
  logic [CNT_W-1:0] retired_q;

  // Without memory wait states every access completes in one cycle.
  assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and the opcode-dependent illegal flag in DECODE.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:   if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        if (Op == OP_LW || Op == OP_SW)    state_d = S_MEMADR;
        else if (Op == OP_RTYPE)           state_d = S_EXECUTE;
        else if (Op == OP_BEQ)             state_d = S_BRANCH;
        else if (EN_ADDI && Op == OP_ADDI) state_d = S_ADDIEX;
        else if (EN_JUMP && Op == OP_J)    state_d = S_JUMP;
        else                               illegal = 1'b1;
      end
      S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_rdy) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl)
  );

  // Retired counter: one step per completed instruction, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               retired_q <= '0;
    else if (ctrl.instr_done) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.memto_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign ALUOp      = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = illegal;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule
